// File: rtl/prog_loader.sv
// prog_loader: receives a program as a byte stream and writes it into a
// 256 x 16-bit instruction memory. The processor is held in reset during the
// load and fetches from the loaded image once the load is done.
//
// Optional feature: define PROG_LOADER_CKSUM_EN to accept one checksum byte
// after the last word. An 8-bit running sum of the data bytes plus that byte
// must be 0 mod 256, otherwise err is raised. The image is still used.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   start      begin a load (honoured in IDLE or DONE only)
//   len        number of 16-bit words to load, sampled with start
//   byte_in    load data byte, high byte of each word first
//   byte_valid byte_in is valid this cycle
//   byte_ready block accepts byte_in this cycle
//   pc         processor fetch address
//   ir         instruction at pc once loaded, HALT (16'hF000) otherwise
//   cpu_hold   processor must stay stalled while high
//   done       load complete, memory valid
//   wr_addr    next word address to be written (LED display)
//   err        checksum mismatch on the last load (0 without the checksum)
module prog_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  len,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [7:0]  pc,
    output logic [15:0] ir,
    output logic        cpu_hold,
    output logic        done,
    output logic [7:0]  wr_addr,
    output logic        err
);

    localparam int unsigned AW    = 8;
    localparam int unsigned BW    = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 256;
    localparam logic [DW-1:0] HALT = DW'(16'hF000);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HI    = 3'd1,
        S_LO    = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
`ifdef PROG_LOADER_CKSUM_EN
        ,S_CKSUM = 3'd5
`endif
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   len_q;
    logic [BW-1:0]   hi_q;
    logic [BW-1:0]   lo_q;
    logic [DW-1:0]   mem [DEPTH];

    logic xfer_c;
    logic load_c;
    logic last_word_c;
    logic ready_d_c;

    assign xfer_c      = byte_valid & byte_ready;
    assign load_c      = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    // len_q is never 0 while words are being written
    assign last_word_c = (wr_addr == (len_q - AW'(1)));

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = (len != '0) ? S_HI : S_DONE;
            end
            S_HI:    if (xfer_c) state_d = S_LO;
            S_LO:    if (xfer_c) state_d = S_WRITE;
            S_WRITE: begin
`ifdef PROG_LOADER_CKSUM_EN
                state_d = last_word_c ? S_CKSUM : S_HI;
`else
                state_d = last_word_c ? S_DONE : S_HI;
`endif
            end
`ifdef PROG_LOADER_CKSUM_EN
            S_CKSUM: if (xfer_c) state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake ready decoded from the next state so the output is registered
    always_comb begin
        ready_d_c = (state_d == S_HI) | (state_d == S_LO);
`ifdef PROG_LOADER_CKSUM_EN
        ready_d_c = ready_d_c | (state_d == S_CKSUM);
`endif
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            wr_addr    <= '0;
            len_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            byte_ready <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_ready <= ready_d_c;
            cpu_hold   <= (state_d != S_DONE);
            done       <= (state_d == S_DONE);
            if (load_c) begin
                wr_addr <= '0;
                len_q   <= len;
            end
            if ((state_q == S_HI) && xfer_c) hi_q <= byte_in;
            if ((state_q == S_LO) && xfer_c) lo_q <= byte_in;
            if (state_q == S_WRITE) wr_addr <= wr_addr + AW'(1);
        end
    end

    // Instruction storage: not reset, so an abandoned load keeps its words
    always_ff @(posedge clk) begin
        if (state_q == S_WRITE) mem[wr_addr] <= {hi_q, lo_q};
    end

    // Fetch port: image only visible once a load has completed
    assign ir = done ? mem[pc] : HALT;

`ifdef PROG_LOADER_CKSUM_EN
    logic [BW-1:0] sum_q;

    // Running byte sum and checksum verdict
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
            err   <= 1'b0;
        end else if (load_c) begin
            sum_q <= '0;
            err   <= 1'b0;
        end else if (((state_q == S_HI) || (state_q == S_LO)) && xfer_c) begin
            sum_q <= BW'(sum_q + byte_in);
        end else if ((state_q == S_CKSUM) && xfer_c) begin
            err   <= (BW'(sum_q + byte_in) != '0);
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed cases plus random loads,
// compared against a word-level model of the loaded image.
module tb_prog_loader;

`ifdef PROG_LOADER_CKSUM_EN
    localparam int CK_EXTRA = 1;
`else
    localparam int CK_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [7:0]  pc;
    logic [15:0] ir;
    logic        cpu_hold;
    logic        done;
    logic [7:0]  wr_addr;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] words   [256];

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .byte_in   (byte_in),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .pc        (pc),
        .ir        (ir),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .wr_addr   (wr_addr),
        .err       (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one byte and hold it until accepted; returns the accepting edge
    task automatic send_byte(input logic [7:0] b, output int edge_no);
        int n;
        n = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("byte_ready_timeout", 32'd0, 32'd1);
        edge_no = cyc + 1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int g);
        repeat (g) begin
            byte_in = 8'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic verify_ir(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) begin
            pc = 8'(a);
            #1;
            check("ir_fetch", 32'(ir), 32'(ref_mem[a]));
        end
        @(negedge clk);
    endtask

    // Full load of words[0..L-1]; ck_mode 1 sends the correct checksum,
    // 0 sends ck_val. poke_lo pulses start while in LO of the first word.
    task automatic do_load(input int L, input int gap, input int ck_mode,
                           input logic [7:0] ck_val, input bit poke_lo);
        int first_e, e, lat, n, sum;
        logic [7:0] ck;
        bit exp_err;
        start = 1'b1;
        len   = 8'(L);
        @(negedge clk);
        start = 1'b0;
        len   = 8'($urandom);
        sum = 0;
        first_e = 0;
        for (int w = 0; w < L; w++) begin
            send_byte(words[w][15:8], e);
            if (w == 0) first_e = e;
            sum += int'(words[w][15:8]);
            if (poke_lo && w == 0) begin
                start = 1'b1;
                len   = 8'd5;
                @(negedge clk);
                start = 1'b0;
                check("start_ignored_ready", 32'(byte_ready), 32'd1);
                check("start_ignored_addr", 32'(wr_addr), 32'd0);
            end
            idle_cycles(gap);
            send_byte(words[w][7:0], e);
            sum += int'(words[w][7:0]);
            check("ready_in_write", 32'(byte_ready), 32'd0);
            check("hold_busy", 32'(cpu_hold), 32'd1);
            check("done_busy", 32'(done), 32'd0);
            idle_cycles(gap);
        end
        ck = (ck_mode == 1) ? 8'(256 - (sum % 256)) : ck_val;
        exp_err = 1'b0;
`ifdef PROG_LOADER_CKSUM_EN
        send_byte(ck, e);
        exp_err = ((sum + int'(ck)) % 256) != 0;
`endif
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", 32'(done), 32'd1);
        lat = cyc - first_e + 1;
        if (gap == 0 && !poke_lo) check("latency", 32'(lat), 32'(3 * L + CK_EXTRA));
        for (int w = 0; w < L; w++) ref_mem[w] = words[w];
        check("wr_addr_final", 32'(wr_addr), 32'(L % 256));
        check("err_final", 32'(err), 32'(exp_err));
        check("hold_released", 32'(cpu_hold), 32'd0);
        check("ready_done", 32'(byte_ready), 32'd0);
        verify_ir(0, L - 1);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_ir"}, 32'(ir), 32'h0000F000);
        check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        int e, L, g;
        reset = 1'b0;
        start = 1'b0;
        len = '0;
        byte_in = '0;
        byte_valid = 1'b0;
        pc = '0;
        repeat (3) @(negedge clk);
        reset_values("in_reset");
        reset = 1'b1;
        @(negedge clk);
        reset_values("after_reset");

        // len=0 from IDLE goes straight to DONE
        start = 1'b1;
        len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0_idle_done", 32'(done), 32'd1);
        check("len0_idle_wr_addr", 32'(wr_addr), 32'd0);
        check("len0_idle_hold", 32'(cpu_hold), 32'd0);

        // Two-word load, continuous bytes
        words[0] = 16'h2000;
        words[1] = 16'h2011;
        do_load(2, 0, 0, 8'h8F, 1'b0);
        pc = 8'd1;
        #1;
        check("ir_pc1", 32'(ir), 32'h00002011);
        @(negedge clk);

        // Same data with 3-cycle gaps
        do_load(2, 3, 0, 8'h8F, 1'b0);

        // start pulsed during LO is ignored
        words[0] = 16'($urandom);
        do_load(1, 0, 1, 8'h00, 1'b1);

        // len=0 from DONE
        start = 1'b1;
        len = 8'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0_done_done", 32'(done), 32'd1);
        check("len0_done_wr_addr", 32'(wr_addr), 32'd0);
        check("len0_done_err", 32'(err), 32'd0);

        // Reset in HI of word 5 of a 10-word load
        for (int w = 0; w < 10; w++) words[w] = 16'($urandom);
        start = 1'b1;
        len = 8'd10;
        @(negedge clk);
        start = 1'b0;
        for (int w = 0; w < 4; w++) begin
            send_byte(words[w][15:8], e);
            send_byte(words[w][7:0], e);
        end
        @(negedge clk);
        check("word5_hi_ready", 32'(byte_ready), 32'd1);
        check("word5_hi_wr_addr", 32'(wr_addr), 32'd4);
        reset = 1'b0;
        #1;
        reset_values("mid_load_reset");
        for (int w = 0; w < 4; w++) ref_mem[w] = words[w];
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        words[0] = 16'($urandom);
        do_load(1, 0, 1, 8'h00, 1'b0);
        check("reload_done", 32'(done), 32'd1);
        verify_ir(1, 3);

`ifdef PROG_LOADER_CKSUM_EN
        words[0] = 16'hF000;
        do_load(1, 0, 0, 8'h11, 1'b0);
        check("cksum_bad_err", 32'(err), 32'd1);
        do_load(1, 0, 0, 8'h10, 1'b0);
        check("cksum_good_err", 32'(err), 32'd0);
`endif

        // Random loads
        for (int it = 0; it < 8; it++) begin
            L = $urandom_range(1, 40);
            g = $urandom_range(0, 2);
            for (int w = 0; w < L; w++) words[w] = 16'($urandom);
            do_load(L, g, $urandom_range(0, 1), 8'($urandom), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 The block SHALL have `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have `reset`, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-003 The block SHALL have `start`, input, 1 bit: begins a load when sampled high in IDLE or DONE.
REQ-004 The block SHALL have `len`, input, 8 bits: number of 16-bit instruction words to load, sampled with `start`.
REQ-005 The block SHALL have `byte_in`, input, 8 bits: load data byte.
REQ-006 The block SHALL have `byte_valid`, input, 1 bit: `byte_in` is valid this cycle.
REQ-007 The block SHALL have `byte_ready`, output, 1 bit: the block accepts `byte_in` this cycle.
REQ-008 The block SHALL have `pc`, input, 8 bits: processor fetch address.
REQ-009 The block SHALL have `ir`, output, 16 bits: instruction word returned for `pc`.
REQ-010 The block SHALL have `cpu_hold`, output, 1 bit: processor must stay stalled/reset while high.
REQ-011 The block SHALL have `done`, output, 1 bit: a load has completed and memory is valid.
REQ-012 The block SHALL have `wr_addr`, output, 8 bits: next word address to be written, for LED display.
REQ-013 The block SHALL have `err`, output, 1 bit: checksum mismatch on the last load.

Function
REQ-014 The block SHALL contain 256 x 16-bit instruction storage, written only by this block.
REQ-015 The block SHALL transfer a byte only on a cycle with `byte_valid`=1 and `byte_ready`=1; other cycles have no effect.
REQ-016 The states SHALL be IDLE, HI, LO, WRITE, CKSUM and DONE.
REQ-017 In IDLE or DONE: `start`=1 with `len`!=0 SHALL go to HI, clear `wr_addr` to 0, latch `len` and clear `done` and `err`.
REQ-018 In IDLE or DONE: `start`=1 with `len`=0 SHALL go directly to DONE with no writes and `err`=0.
REQ-019 In HI: a transfer SHALL latch `byte_in` as word bits [15:8] and go to LO.
REQ-020 In LO: a transfer SHALL latch `byte_in` as word bits [7:0] and go to WRITE.
REQ-021 `byte_ready` SHALL be 1 only in HI, LO and CKSUM.
REQ-022 In WRITE (exactly one cycle): the assembled word SHALL be stored at `wr_addr` and `wr_addr` incremented modulo 256.
REQ-023 From WRITE, the block SHALL go to HI if fewer than `len` words are written, otherwise to CKSUM (macro defined) or DONE.
REQ-024 Latency SHALL be the byte-arrival time plus one WRITE cycle per word; with continuous `byte_valid`, each word takes 3 cycles.
REQ-025 `start` SHALL be ignored in HI, LO, WRITE and CKSUM.
REQ-026 `cpu_hold` SHALL be 1 in every state except DONE.
REQ-027 `done` SHALL be 1 only in DONE.
REQ-028 `ir` SHALL be combinational: memory[`pc`] in DONE, otherwise 16'hF000 (HALT).
REQ-029 `wr_addr` SHALL wrap from 8'hFF to 8'h00 when `len` reaches 256 words, which is not reachable because `len` is at most 255.

Reset
REQ-030 Asserted `reset` SHALL immediately force: state IDLE, `wr_addr`=0, `done`=0, `err`=0, `byte_ready`=0, `cpu_hold`=1, `ir`=16'hF000.
REQ-031 Reset mid-load SHALL abandon the load; words already written SHALL be retained but not visible until a new load completes.
REQ-032 Instruction storage SHALL NOT be cleared by reset.

Configuration
REQ-033 Macro `PROG_LOADER_CKSUM_EN`, when defined, SHALL enable CKSUM: an 8-bit running sum (mod 256) of all data bytes is kept, and one further byte is accepted after the last word.
REQ-034 With `PROG_LOADER_CKSUM_EN` defined, if (sum + checksum byte) mod 256 != 0 the block SHALL set `err`=1 on entering DONE; the memory is still used.
REQ-035 With `PROG_LOADER_CKSUM_EN` undefined, CKSUM SHALL be absent, WRITE of the last word SHALL go to DONE, and `err` SHALL be constant 0.

Verification
REQ-036 The bench SHALL cover: release reset -> `ir`=F000, `cpu_hold`=1, `done`=0, `wr_addr`=0.
REQ-037 The bench SHALL cover: `start` with `len`=2, bytes 20,00,20,11 continuous -> mem[0]=2000, mem[1]=2011, `done` high 6 cycles after the first byte (7 with CKSUM plus checksum byte 8F), `pc`=1 -> `ir`=2011.
REQ-038 The bench SHALL cover: `byte_valid` gaps of 3 cycles between bytes -> same memory contents and no extra writes; `byte_ready`=0 in WRITE.
REQ-039 The bench SHALL cover: `start` pulsed during LO -> ignored; `start` with `len`=0 -> DONE next cycle, `wr_addr`=0.
REQ-040 The bench SHALL cover: reset asserted during HI of word 5 of 10 -> IDLE, `ir`=F000; a reload of 1 word then yields `done`=1.
REQ-041 The bench SHALL cover, with CKSUM enabled: load 1 word F0,00 with checksum 11 -> `err`=1; with checksum 10 -> `err`=0.
